// File: rtl/uart_tx_unit_pkg.sv
// uart_tx_unit_pkg: shared UART types and constants.
// Provides the 2-bit transmit FSM encoding, the baud divisor helper and the
// default oversampling and data-width constants that the receive side also uses.
package uart_tx_unit_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;
    localparam int DEF_OVS  = 16;
    localparam int DEF_DBIT = 8;
    function automatic int calc_dvsr(input int clk_hz, input int baud, input int ovs);
        return clk_hz / (baud * ovs);
    endfunction
endpackage

// File: rtl/uart_tx_unit_baud_gen.sv
// uart_tx_unit_baud_gen: oversampling tick generator.
// Ports: clk, reset (sync, active high), i_clr restarts the count at 0,
// o_tick is high for one cycle when the counter reaches DVSR-1.
module uart_tx_unit_baud_gen #(
    parameter int DVSR = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    output logic o_tick
);
    localparam int CW = (DVSR > 1) ? $clog2(DVSR) : 1;
    localparam logic [CW-1:0] LAST = CW'(DVSR - 1);
    logic [CW-1:0] r_cnt;
    always_ff @(posedge clk) begin
        if (reset || i_clr)
            r_cnt <= '0;
        else
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end
    assign o_tick = (r_cnt == LAST);
endmodule

// File: rtl/uart_tx_unit.sv
// uart_tx_unit: 8N1 UART transmitter with write FIFO and baud generator.
// Ports: clk, reset (sync, active high), wr_uart/w_data push a byte,
// tx_full/tx_empty report the registered FIFO state, tx_busy is high outside
// IDLE, tx is the registered serial line (idles high).
module uart_tx_unit
    import uart_tx_unit_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int BAUD    = 9600,
    parameter int OVS     = DEF_OVS,
    parameter int DBIT    = DEF_DBIT,
    parameter int SB_TICK = 16,
    parameter int FIFO_AW = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_uart,
    input  logic [DBIT-1:0] w_data,
    output logic            tx_full,
    output logic            tx_empty,
    output logic            tx_busy,
    output logic            tx
);
    localparam int DVSR  = calc_dvsr(CLK_HZ, BAUD, OVS);
    localparam int SMAX  = (OVS > SB_TICK) ? OVS : SB_TICK;
    localparam int SW    = (SMAX > 1) ? $clog2(SMAX) : 1;
    localparam int NW    = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam logic [SW-1:0] S_OVS  = SW'(OVS - 1);
    localparam logic [SW-1:0] S_SB   = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

    logic [DBIT-1:0]    r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wptr, r_rptr;
    logic [FIFO_AW:0]   r_cnt;
    logic               r_full, r_empty;
    logic               w_push, w_pop, w_tick;
    logic [FIFO_AW:0]   w_cnt;
    tx_state_t          r_state, w_state;
    logic [SW-1:0]      r_s, w_s;
    logic [NW-1:0]      r_n, w_n;
    logic [DBIT-1:0]    r_b, w_b;
    logic               r_tx, w_tx;

    uart_tx_unit_baud_gen #(.DVSR(DVSR)) u_baud (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (w_pop),
        .o_tick (w_tick)
    );

    // A write while full is dropped even if a pop frees a slot this cycle.
    assign w_push = wr_uart & ~r_full;
    assign w_cnt  = r_cnt + {{FIFO_AW{1'b0}}, w_push} - {{FIFO_AW{1'b0}}, w_pop};

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr] <= w_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_cnt   <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            r_wptr  <= r_wptr + {{(FIFO_AW-1){1'b0}}, w_push};
            r_rptr  <= r_rptr + {{(FIFO_AW-1){1'b0}}, w_pop};
            r_cnt   <= w_cnt;
            r_full  <= (w_cnt == (FIFO_AW+1)'(DEPTH));
            r_empty <= (w_cnt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_s     <= '0;
            r_n     <= '0;
            r_b     <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state;
            r_s     <= w_s;
            r_n     <= w_n;
            r_b     <= w_b;
            r_tx    <= w_tx;
        end
    end

    always_comb begin
        w_state = r_state;
        w_s     = r_s;
        w_n     = r_n;
        w_b     = r_b;
        w_pop   = 1'b0;
        case (r_state)
            IDLE: begin
                if (!r_empty) begin
                    w_pop   = 1'b1;
                    w_b     = r_mem[r_rptr];
                    w_s     = '0;
                    w_state = START;
                end
            end
            START: begin
                if (w_tick) begin
                    if (r_s == S_OVS) begin
                        w_s     = '0;
                        w_n     = '0;
                        w_state = DATA;
                    end else
                        w_s = r_s + 1'b1;
                end
            end
            DATA: begin
                if (w_tick) begin
                    if (r_s == S_OVS) begin
                        w_s = '0;
                        w_b = r_b >> 1;
                        if (r_n == N_LAST)
                            w_state = STOP;
                        else
                            w_n = r_n + 1'b1;
                    end else
                        w_s = r_s + 1'b1;
                end
            end
            STOP: begin
                if (w_tick)
                    if (r_s == S_SB)
                        w_state = IDLE;
                    else
                        w_s = r_s + 1'b1;
            end
            default: w_state = IDLE;
        endcase
        // Line level follows the next state so it moves on the same edge.
        w_tx = (w_state == START) ? 1'b0 : (w_state == DATA) ? w_b[0] : 1'b1;
    end

    assign tx_full  = r_full;
    assign tx_empty = r_empty;
    assign tx_busy  = (r_state != IDLE);
    assign tx       = r_tx;
endmodule

// File: tb/tb_uart_tx_unit.sv
// tb_uart_tx_unit: directed scoreboard bench for uart_tx_unit (1 and 2 stop-bit builds).
module tb_uart_tx_unit;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr = 1'b0, wr2 = 1'b0;
    logic [7:0] wd = 8'h00, wd2 = 8'h00;
    logic       full, empty, busy, tx;
    logic       full2, empty2, busy2, tx2;
    int         cyc = 0;
    int         n_assert = 0;
    int         n_fail = 0;
    bit         mon_en = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_q2[$];
    int         sq[$];
    int         sq2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_unit #(.CLK_HZ(1_600_000), .BAUD(10_000), .OVS(16), .DBIT(8), .SB_TICK(16), .FIFO_AW(4)) dut (
        .clk(clk), .reset(reset), .wr_uart(wr), .w_data(wd),
        .tx_full(full), .tx_empty(empty), .tx_busy(busy), .tx(tx)
    );

    uart_tx_unit #(.CLK_HZ(1_600_000), .BAUD(10_000), .OVS(16), .DBIT(8), .SB_TICK(32), .FIFO_AW(4)) dut2 (
        .clk(clk), .reset(reset), .wr_uart(wr2), .w_data(wd2),
        .tx_full(full2), .tx_empty(empty2), .tx_busy(busy2), .tx(tx2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input bit which, input logic [7:0] d, input bit acc);
        if (which) begin
            wr2 = 1'b1;
            wd2 = d;
            if (acc) exp_q2.push_back(d);
        end else begin
            wr = 1'b1;
            wd = d;
            if (acc) exp_q.push_back(d);
        end
        @(negedge clk);
        wr  = 1'b0;
        wr2 = 1'b0;
    endtask

    task automatic wait_idle(input bit which, input int budget);
        int c = 0;
        while (((which ? exp_q2.size() : exp_q.size()) != 0 || (which ? busy2 : busy) !== 1'b0) && c < budget) begin
            @(negedge clk);
            c++;
        end
        check(which ? "drain2" : "drain", 32'(c < budget), 1);
    endtask

    task automatic mon(input bit which);
        logic       line [1760];
        int         flen, sb, t0, base, len;
        logic [7:0] ev, got;
        logic       eb;
        bit         had;
        flen = which ? 1760 : 1600;
        sb   = which ? 320 : 160;
        forever begin
            @(negedge clk);
            if (mon_en && (which ? tx2 : tx) === 1'b0) begin
                t0 = cyc;
                line[0] = 1'b0;
                for (int i = 1; i < flen; i++) begin
                    @(negedge clk);
                    line[i] = which ? tx2 : tx;
                end
                got = 8'h00;
                if (which) begin
                    had = exp_q2.size() > 0;
                    ev  = had ? exp_q2.pop_front() : 8'h00;
                    sq2.push_back(t0);
                end else begin
                    had = exp_q.size() > 0;
                    ev  = had ? exp_q.pop_front() : 8'h00;
                    sq.push_back(t0);
                end
                check(which ? "frame_expected2" : "frame_expected", 32'(had), 1);
                for (int k = 0; k < 10; k++) begin
                    base = 160 * k;
                    len  = (k == 9) ? sb : 160;
                    if (k == 0) eb = 1'b0;
                    else if (k == 9) eb = 1'b1;
                    else begin
                        eb = ev[k-1];
                        got[k-1] = line[base + 80];
                    end
                    check(which ? "bit_first2" : "bit_first", 32'(line[base]), 32'(eb));
                    check(which ? "bit_last2" : "bit_last", 32'(line[base + len - 1]), 32'(eb));
                end
                check(which ? "byte2" : "byte", 32'(got), 32'(ev));
            end
        end
    endtask

    initial mon(1'b0);
    initial mon(1'b1);

    initial begin
        #2ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lows;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            check("rst_tx", 32'(tx), 1);
            check("rst_busy", 32'(busy), 0);
            check("rst_empty", 32'(empty), 1);
            check("rst_full", 32'(full), 0);
        end
        check("rst_tx2", 32'(tx2), 1);
        check("rst_empty2", 32'(empty2), 1);
        mon_en = 1'b1;

        push(1'b0, 8'hA5, 1'b1);
        check("a5_tx_n", 32'(tx), 1);
        check("a5_empty_n", 32'(empty), 0);
        check("a5_busy_n", 32'(busy), 0);
        @(negedge clk);
        check("a5_tx_n1", 32'(tx), 0);
        check("a5_busy_n1", 32'(busy), 1);
        check("a5_empty_n1", 32'(empty), 1);
        repeat (1599) @(negedge clk);
        check("a5_busy_1599", 32'(busy), 1);
        @(negedge clk);
        check("a5_busy_1600", 32'(busy), 0);
        check("a5_tx_idle", 32'(tx), 1);
        wait_idle(1'b0, 200);

        sq.delete();
        push(1'b0, 8'h00, 1'b1);
        push(1'b0, 8'hFF, 1'b1);
        push(1'b0, 8'h55, 1'b1);
        check("b2b_empty_q", 32'(empty), 0);
        repeat (3200) @(negedge clk);
        check("b2b_empty_pre", 32'(empty), 0);
        @(negedge clk);
        check("b2b_empty_pop3", 32'(empty), 1);
        wait_idle(1'b0, 2000);
        check("b2b_frames", sq.size(), 3);
        if (sq.size() == 3) begin
            check("b2b_gap1", 32'(sq[1] - sq[0]), 1601);
            check("b2b_gap2", 32'(sq[2] - sq[1]), 1601);
        end

        for (int i = 0; i < 17; i++) begin
            push(1'b0, 8'(8'h10 + i), 1'b1);
            if (i == 15) check("fill_not_full", 32'(full), 0);
        end
        check("fill_full", 32'(full), 1);
        push(1'b0, 8'h99, 1'b0);
        check("drop_full", 32'(full), 1);
        wait_idle(1'b0, 17 * 1601 + 200);
        repeat (200) @(negedge clk);
        check("fill_done_empty", 32'(empty), 1);
        check("fill_done_busy", 32'(busy), 0);
        check("fill_done_q", exp_q.size(), 0);

        mon_en = 1'b0;
        push(1'b0, 8'hC3, 1'b0);
        push(1'b0, 8'h3C, 1'b0);
        repeat (399) @(negedge clk);
        check("mid_busy", 32'(busy), 1);
        check("mid_empty", 32'(empty), 0);
        reset = 1'b1;
        @(negedge clk);
        check("abort_tx", 32'(tx), 1);
        check("abort_busy", 32'(busy), 0);
        check("abort_empty", 32'(empty), 1);
        check("abort_full", 32'(full), 0);
        reset = 1'b0;
        lows = 0;
        repeat (2000) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) lows++;
        end
        check("no_resume", lows, 0);
        check("no_resume_empty", 32'(empty), 1);
        mon_en = 1'b1;

        sq2.delete();
        push(1'b1, 8'h81, 1'b1);
        push(1'b1, 8'h7E, 1'b1);
        wait_idle(1'b1, 3 * 1761 + 100);
        check("sb32_frames", sq2.size(), 2);
        if (sq2.size() == 2)
            check("sb32_gap", 32'(sq2[1] - sq2[0]), 1761);
        check("sb32_tx_idle", 32'(tx2), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
